gpr_wr_arbiter: RTL
===================

Name: gpr_wr_arbiter

Overview:
Shares the single GPR write port between NUM_REQ writeback requesters (ALU, load unit, CSR/mul, ...) plus one high-priority debug port. Requesters use a valid/ready handshake. Arbitration is round-robin, and the debug port has a bounded-run override. The winning write is registered and driven onto the GPR write bus as active-low write enable, address and data, one cycle after acceptance.

Parameters:
NUM_REQ, 3, number of round-robin writeback requesters (2..8)
ADDR_W, 5, GPR address width
DATA_W, 32, GPR data width
MAX_DBG_RUN, 4, max consecutive debug grants while any requester is pending

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
stall  in  1  freeze: no grants this cycle
req_valid  in  NUM_REQ  per-requester write request
req_addr  in  NUM_REQ*ADDR_W  packed target address, requester i at [i*ADDR_W +: ADDR_W]
req_data  in  NUM_REQ*DATA_W  packed write data, same packing
req_ready  out  NUM_REQ  one-hot grant; transfer when valid&ready
dbg_valid  in  1  debug write request
dbg_addr  in  ADDR_W  debug target address
dbg_data  in  DATA_W  debug write data
dbg_ready  out  1  debug grant
gpr_we_n  out  1  GPR write enable, active-low
gpr_addr  out  ADDR_W  GPR write address
gpr_data  out  DATA_W  GPR write data
rr_ptr  out  $clog2(NUM_REQ)  current round-robin priority pointer (debug/visibility)

Behaviour:
- Reset values: gpr_we_n=1, gpr_addr=0, gpr_data=0, rr_ptr=0, debug run counter=0.
- Outputs are registered. A write accepted in cycle N appears on gpr_* in cycle N+1 only, with gpr_we_n=0 for exactly that cycle. With no acceptance in cycle N, gpr_we_n=1 in N+1; addr and data hold their last values.
- Grants are combinational from the current inputs and state. At most one of {req_ready[*], dbg_ready} is high. Ready is asserted only to a requester whose valid is high.
- Requesters hold valid, addr and data stable until ready. Deasserting valid before ready is legal; the request is simply dropped.
- stall=1: all ready outputs are 0, rr_ptr and the run counter are unchanged, and next-cycle gpr_we_n=1.
- Debug priority: dbg_valid wins when run counter < MAX_DBG_RUN, or when no req_valid bit is set.
- Run counter:
  - increments on each debug grant while any req_valid is pending, saturating at MAX_DBG_RUN;
  - clears on any requester grant or when dbg_valid=0.
- At MAX_DBG_RUN with a requester pending: debug is blocked for one cycle and a requester is granted, which clears the counter.
- Round-robin: search req_valid starting at index rr_ptr, wrapping modulo NUM_REQ; the first set bit wins.
- After a requester grant to index i: rr_ptr <= (i+1) mod NUM_REQ, with wrap from NUM_REQ-1 to 0. rr_ptr is unchanged on debug grants or idle cycles.
- Same target address from several requesters: no merging. Each write is granted in a separate cycle in arbitration order; the last write granted wins in the GPR.
- Address 0 writes are passed through unmodified. The arbiter has no knowledge of register semantics.
- Reset mid-operation: the registered write is cancelled (gpr_we_n=1 in the cycle after rst is sampled high), requests pending at reset are not granted during reset, and arbitration restarts with rr_ptr=0.
- No combinational path from gpr_* back to ready. Ready depends only on valid, stall, rr_ptr and the run counter.

Test Plan:
- Single write: req_valid=3'b010, addr=7, data=32'hDEADBEEF at cycle 1 -> req_ready=3'b010 in cycle 1; cycle 2 gpr_we_n=0, gpr_addr=7, gpr_data=DEADBEEF; cycle 3 gpr_we_n=1; rr_ptr=2.
- Round-robin fairness: all three requesters held valid for 6 cycles from rr_ptr=0 -> grant order 0,1,2,0,1,2; gpr_we_n low on 6 consecutive cycles; rr_ptr returns to 0.
- Debug bound: dbg_valid and req_valid[0] held continuously, MAX_DBG_RUN=4 -> grants D,D,D,D,R0,D,D,D,D,R0...; dbg_ready never high more than 4 consecutive cycles.
- Stall: all requests valid, stall=1 for 3 cycles -> ready all 0 and gpr_we_n=1 throughout, rr_ptr unchanged; the first grant after release goes to the index at rr_ptr.
- Same address: req 0 addr=3 data=1, req 2 addr=3 data=2, rr_ptr=0 -> writes appear on consecutive cycles, data 1 then 2; final GPR r3=2.
- Reset mid-stream: rst=1 in the cycle after a grant -> gpr_we_n=1 in the following cycle, all ready outputs 0 while rst=1, and rr_ptr=0 after reset.

Source files
------------

// File: rtl/gpr_wr_arbiter_if.sv
// gpr_wr_arbiter_if: writeback request/grant bundle plus the GPR write bus.
// Ports (via modports):
//   master: drives stall, req_valid/addr/data, dbg_valid/addr/data;
//           sees req_ready, dbg_ready, gpr_we_n/addr/data, rr_ptr.
//   slave : the arbiter side, directions mirrored.
interface gpr_wr_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32
);
    localparam int PW = $clog2(NUM_REQ);

    logic                      stall;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      dbg_valid;
    logic [ADDR_W-1:0]         dbg_addr;
    logic [DATA_W-1:0]         dbg_data;
    logic                      dbg_ready;
    logic                      gpr_we_n;
    logic [ADDR_W-1:0]         gpr_addr;
    logic [DATA_W-1:0]         gpr_data;
    logic [PW-1:0]             rr_ptr;

    modport master (
        output stall, req_valid, req_addr, req_data,
        output dbg_valid, dbg_addr, dbg_data,
        input  req_ready, dbg_ready,
        input  gpr_we_n, gpr_addr, gpr_data, rr_ptr
    );

    modport slave (
        input  stall, req_valid, req_addr, req_data,
        input  dbg_valid, dbg_addr, dbg_data,
        output req_ready, dbg_ready,
        output gpr_we_n, gpr_addr, gpr_data, rr_ptr
    );
endinterface

// File: rtl/gpr_wr_arbiter.sv
// gpr_wr_arbiter: shares the GPR write port between NUM_REQ round-robin
// writeback requesters and a debug port with a bounded-run override.
// Ports: clk, rst (sync, active-high), bus (gpr_wr_arbiter_if.slave):
//   stall, req_valid/addr/data -> req_ready (one-hot),
//   dbg_valid/addr/data -> dbg_ready, registered gpr_we_n/addr/data,
//   rr_ptr (current round-robin priority).
module gpr_wr_arbiter #(
    parameter int NUM_REQ     = 3,
    parameter int ADDR_W      = 5,
    parameter int DATA_W      = 32,
    parameter int MAX_DBG_RUN = 4
) (
    input logic             clk,
    input logic             rst,
    gpr_wr_arbiter_if.slave bus
);
    localparam int PW = $clog2(NUM_REQ);
    localparam int CW = $clog2(MAX_DBG_RUN + 1);
    localparam logic [PW:0]   NR      = (PW+1)'(NUM_REQ);
    localparam logic [CW-1:0] RUN_MAX = CW'(MAX_DBG_RUN);

    logic [PW-1:0]     r_ptr;
    logic [CW-1:0]     r_run;
    logic              r_we_n;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;

    logic                   w_open;
    logic                   w_any;
    logic                   w_dbg_gnt;
    logic                   w_req_gnt;
    logic [2*NUM_REQ-1:0]   w_dbl;
    logic [2*NUM_REQ-1:0]   w_sh;
    logic [NUM_REQ-1:0]     w_rot;
    logic [PW-1:0]          w_off;
    logic [PW:0]            w_sum;
    logic [PW:0]            w_inc;
    logic [PW-1:0]          w_idx;
    logic [PW-1:0]          w_nxt_ptr;
    logic [ADDR_W-1:0]      w_sel_addr;
    logic [DATA_W-1:0]      w_sel_data;
    logic [CW-1:0]          w_run_nxt;

    // Round-robin search: rotate the valid vector so rr_ptr lands at
    // bit 0, take the lowest set bit, then undo the rotation.
    always_comb begin
        w_dbl = {bus.req_valid, bus.req_valid};
        w_sh  = w_dbl >> r_ptr;
        w_rot = w_sh[NUM_REQ-1:0];
        w_off = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_rot[PW'(k)]) begin
                w_off = PW'(k);
            end
        end
        w_sum = {1'b0, r_ptr} + {1'b0, w_off};
        if (w_sum >= NR) begin
            w_sum = w_sum - NR;
        end
        w_idx = w_sum[PW-1:0];
        w_inc = {1'b0, w_idx} + (PW+1)'(1);
        w_nxt_ptr = (w_inc == NR) ? '0 : w_inc[PW-1:0];
    end

    always_comb begin
        w_sel_addr = '0;
        w_sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_idx == PW'(i)) begin
                w_sel_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
                w_sel_data = bus.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Grants look only at valids, stall, rst and local state, never at
    // the registered write bus.
    always_comb begin
        w_open    = !rst && !bus.stall;
        w_any     = |bus.req_valid;
        w_dbg_gnt = w_open && bus.dbg_valid
                    && (!w_any || (r_run < RUN_MAX));
        w_req_gnt = w_open && w_any && !w_dbg_gnt;
    end

    // The run counter only grows while a requester is actually being
    // held off; a requester grant or an idle debug port clears it.
    always_comb begin
        w_run_nxt = r_run;
        if (w_open) begin
            if (w_req_gnt || !bus.dbg_valid) begin
                w_run_nxt = '0;
            end else if (w_any && (r_run < RUN_MAX)) begin
                w_run_nxt = r_run + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr  <= '0;
            r_run  <= '0;
            r_we_n <= 1'b1;
            r_addr <= '0;
            r_data <= '0;
        end else begin
            r_we_n <= !(w_dbg_gnt || w_req_gnt);
            r_run  <= w_run_nxt;
            if (w_dbg_gnt) begin
                r_addr <= bus.dbg_addr;
                r_data <= bus.dbg_data;
            end else if (w_req_gnt) begin
                r_addr <= w_sel_addr;
                r_data <= w_sel_data;
                r_ptr  <= w_nxt_ptr;
            end
        end
    end

    assign bus.req_ready = w_req_gnt ? (NUM_REQ'(1) << w_idx) : '0;
    assign bus.dbg_ready = w_dbg_gnt;
    assign bus.gpr_we_n  = r_we_n;
    assign bus.gpr_addr  = r_addr;
    assign bus.gpr_data  = r_data;
    assign bus.rr_ptr    = r_ptr;
endmodule
